// File: rtl/karat_mult_seq.sv
// Handshaked one-level Karatsuba multiplier. A single (wI/2+1)-bit sub-multiplier
// is reused over three issue cycles; optional two's-complement operands.
module karat_mult_seq #(
  parameter int unsigned wI        = 512,
  parameter int unsigned wO        = 2 * wI,
  parameter int unsigned MUL_LAT   = 2,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [wI-1:0] iX,
  input  logic [wI-1:0] iY,
  input  logic          i_signed,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [wO-1:0] oO,
  output logic          o_busy
);

  localparam int unsigned H  = wI / 2;
  localparam int unsigned PW = 2 * H + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ISS0, S_ISS1, S_ISS2, S_WAIT, S_COMB, S_DONE
  } state_t;

  state_t        state;
  logic [wI-1:0] x_raw, y_raw, x_mag, y_mag;
  logic          sgn_raw, neg;
  logic [2:0]    wcnt;
  logic          accept, xs, ys;

  assign i_ready = (state == S_IDLE) || ((state == S_DONE) && o_ready);
  assign accept  = i_valid && i_ready;
  assign xs      = sgn_raw & x_raw[wI-1];
  assign ys      = sgn_raw & y_raw[wI-1];

  // Shared sub-multiplier operand selection, one product per issue state.
  logic [H:0]    mul_a, mul_b;
  logic [PW-1:0] mul_p;
  logic          iss_v;
  logic [1:0]    iss_sel;

  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    iss_v   = 1'b0;
    iss_sel = 2'd0;
    case (state)
      S_ISS0: begin
        mul_a   = {1'b0, x_mag[H-1:0]};
        mul_b   = {1'b0, y_mag[H-1:0]};
        iss_v   = 1'b1;
        iss_sel = 2'd0;
      end
      S_ISS1: begin
        mul_a   = {1'b0, x_mag[wI-1:H]};
        mul_b   = {1'b0, y_mag[wI-1:H]};
        iss_v   = 1'b1;
        iss_sel = 2'd1;
      end
      S_ISS2: begin
        mul_a   = {1'b0, x_mag[H-1:0]} + {1'b0, x_mag[wI-1:H]};
        mul_b   = {1'b0, y_mag[H-1:0]} + {1'b0, y_mag[wI-1:H]};
        iss_v   = 1'b1;
        iss_sel = 2'd2;
      end
      default: ;
    endcase
  end

  assign mul_p = PW'(mul_a) * PW'(mul_b);

  logic          res_v;
  logic [1:0]    res_sel;
  logic [PW-1:0] res_p;

  if (MUL_LAT == 0) begin : g_comb
    assign res_v   = iss_v;
    assign res_sel = iss_sel;
    assign res_p   = mul_p;
  end else begin : g_pipe
    logic [MUL_LAT-1:0] pv;
    logic [1:0]         ps [MUL_LAT];
    logic [PW-1:0]      pp [MUL_LAT];

    // Only the valid bits need reset; the data stages are qualified by them.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pv <= '0;
      end else begin
        pv[0] <= iss_v;
        for (int unsigned i = 1; i < MUL_LAT; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      ps[0] <= iss_sel;
      pp[0] <= mul_p;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        ps[i] <= ps[i-1];
        pp[i] <= pp[i-1];
      end
    end

    assign res_v   = pv[MUL_LAT-1];
    assign res_sel = ps[MUL_LAT-1];
    assign res_p   = pp[MUL_LAT-1];
  end

  logic [2*H-1:0] p0, p2;
  logic [PW-1:0]  p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0 <= '0;
      p2 <= '0;
      p1 <= '0;
    end else if (res_v) begin
      case (res_sel)
        2'd0:    p0 <= res_p[2*H-1:0];
        2'd1:    p2 <= res_p[2*H-1:0];
        default: p1 <= res_p;
      endcase
    end
  end

  logic [PW-1:0] mid;
  logic [wO-1:0] r_sum;

  always_comb begin
    mid   = p1 - PW'(p0) - PW'(p2);
    r_sum = wO'(p0) + (wO'(mid) << H) + (wO'(p2) << (2 * H));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      o_valid <= 1'b0;
      oO      <= '0;
      o_busy  <= 1'b0;
      x_raw   <= '0;
      y_raw   <= '0;
      x_mag   <= '0;
      y_mag   <= '0;
      sgn_raw <= 1'b0;
      neg     <= 1'b0;
      wcnt    <= '0;
    end else begin
      if (accept) begin
        x_raw   <= iX;
        y_raw   <= iY;
        sgn_raw <= SIGNED_EN ? i_signed : 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_PREP;
            o_busy <= 1'b1;
          end
        end
        S_PREP: begin
          // Magnitude of the most negative value still fits unsigned in wI bits.
          x_mag <= xs ? ('0 - x_raw) : x_raw;
          y_mag <= ys ? ('0 - y_raw) : y_raw;
          neg   <= xs ^ ys;
          state <= S_ISS0;
        end
        S_ISS0: state <= S_ISS1;
        S_ISS1: state <= S_ISS2;
        S_ISS2: begin
          if (MUL_LAT == 0) begin
            state <= S_COMB;
          end else begin
            state <= S_WAIT;
            wcnt  <= 3'(MUL_LAT - 1);
          end
        end
        S_WAIT: begin
          if (wcnt == 3'd0) state <= S_COMB;
          else              wcnt  <= wcnt - 3'd1;
        end
        S_COMB: begin
          oO      <= neg ? ('0 - r_sum) : r_sum;
          o_valid <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              state <= S_PREP;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karat_mult_seq.sv
// Directed bench for karat_mult_seq: four instances covering narrow signed/unsigned,
// sub-multiplier latency with backpressure, and full 512-bit width edges.
module tb_karat_mult_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Group A: wI=8, MUL_LAT=0, shared by a signed-capable and an unsigned-only instance.
  logic        a_iv, a_s, a_or;
  logic [7:0]  a_x, a_y;
  logic        as_ir, as_ov, as_busy, au_ir, au_ov, au_busy;
  logic [15:0] as_o, au_o;

  // Group B: wI=8, MUL_LAT=2.
  logic        b_iv, b_s, b_or;
  logic [7:0]  b_x, b_y;
  logic        bo_ir, bo_ov, bo_busy;
  logic [15:0] bo_o;

  // Group D: wI=512, MUL_LAT=3.
  logic          d_iv, d_s, d_or;
  logic [511:0]  d_x, d_y;
  logic          dd_ir, dd_ov, dd_busy;
  logic [1023:0] dd_o;

  karat_mult_seq #(.wI(8), .MUL_LAT(0), .SIGNED_EN(1'b1)) u_as (
    .clk(clk), .reset_n(reset_n), .i_valid(a_iv), .i_ready(as_ir), .iX(a_x), .iY(a_y),
    .i_signed(a_s), .o_valid(as_ov), .o_ready(a_or), .oO(as_o), .o_busy(as_busy));

  karat_mult_seq #(.wI(8), .MUL_LAT(0), .SIGNED_EN(1'b0)) u_au (
    .clk(clk), .reset_n(reset_n), .i_valid(a_iv), .i_ready(au_ir), .iX(a_x), .iY(a_y),
    .i_signed(a_s), .o_valid(au_ov), .o_ready(a_or), .oO(au_o), .o_busy(au_busy));

  karat_mult_seq #(.wI(8), .MUL_LAT(2), .SIGNED_EN(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .i_valid(b_iv), .i_ready(bo_ir), .iX(b_x), .iY(b_y),
    .i_signed(b_s), .o_valid(bo_ov), .o_ready(b_or), .oO(bo_o), .o_busy(bo_busy));

  karat_mult_seq #(.wI(512), .MUL_LAT(3), .SIGNED_EN(1'b1)) u_d (
    .clk(clk), .reset_n(reset_n), .i_valid(d_iv), .i_ready(dd_ir), .iX(d_x), .iY(d_y),
    .i_signed(d_s), .o_valid(dd_ov), .o_ready(d_or), .oO(dd_o), .o_busy(dd_busy));

  // Report the first differing 128-bit word so lines stay short for wide products.
  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int unsigned k;
    k = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (obs[i*128 +: 128] !== exp[i*128 +: 128]) begin
        k = i;
        break;
      end
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (128-bit word %0d)",
             tag, obs[k*128 +: 128], exp[k*128 +: 128], k);
    end
  endtask

  task automatic op_a(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic s, input logic [15:0] es, input logic [15:0] eu);
    @(negedge clk);
    a_x = x; a_y = y; a_s = s; a_iv = 1'b1;
    chk({tag, ".ready"}, as_ir, 1'b1);
    @(posedge clk); #1;
    a_iv = 1'b0; a_x = 'x; a_y = 'x; a_s = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk({tag, ".early"}, as_ov, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, as_ov, 1'b1);
    chk({tag, ".prod"}, as_o, es);
    chk({tag, ".uvalid"}, au_ov, 1'b1);
    chk({tag, ".uprod"}, au_o, eu);
  endtask

  task automatic op_d(input string tag, input logic [511:0] x, input logic [511:0] y,
                      input logic s, input logic [1023:0] e);
    @(negedge clk);
    d_x = x; d_y = y; d_s = s; d_iv = 1'b1;
    @(posedge clk); #1;
    d_iv = 1'b0; d_x = 'x; d_y = 'x; d_s = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk({tag, ".early"}, dd_ov, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, dd_ov, 1'b1);
    chk({tag, ".prod"}, dd_o, e);
  endtask

  initial begin
    logic saw;
    reset_n = 1'b0;
    a_iv = 1'b0; a_s = 1'b0; a_or = 1'b1; a_x = '0; a_y = '0;
    b_iv = 1'b0; b_s = 1'b0; b_or = 1'b1; b_x = '0; b_y = '0;
    d_iv = 1'b0; d_s = 1'b0; d_or = 1'b1; d_x = '0; d_y = '0;
    repeat (2) @(negedge clk);
    chk("rst.ov", as_ov, 1'b0);
    chk("rst.o", as_o, 16'h0000);
    chk("rst.ir", as_ir, 1'b1);
    chk("rst.busy", as_busy, 1'b0);
    reset_n = 1'b1;

    op_a("uu_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01);
    op_a("uu_00_a5", 8'h00, 8'hA5, 1'b0, 16'h0000, 16'h0000);
    op_a("s_80_80",  8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000);
    op_a("s_80_7f",  8'h80, 8'h7F, 1'b1, 16'hC080, 16'h3F80);
    op_a("s_ff_01",  8'hFF, 8'h01, 1'b1, 16'hFFFF, 16'h00FF);
    op_a("u_80_80",  8'h80, 8'h80, 1'b0, 16'h4000, 16'h4000);
    op_a("u_80_7f",  8'h80, 8'h7F, 1'b0, 16'h3F80, 16'h3F80);
    op_a("u_ff_01",  8'hFF, 8'h01, 1'b0, 16'h00FF, 16'h00FF);
    op_a("s_ff_ff",  8'hFF, 8'hFF, 1'b1, 16'h0001, 16'hFE01);
    op_a("s_7f_81",  8'h7F, 8'h81, 1'b1, 16'hC0FF, 16'h3FFF);

    // Reset asserted while the operation sits in ISS1; it must vanish.
    @(negedge clk);
    a_x = 8'h35; a_y = 8'h4B; a_s = 1'b0; a_iv = 1'b1;
    @(posedge clk); #1 a_iv = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("mid.busy", as_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst.ov", as_ov, 1'b0);
    chk("mid_rst.o", as_o, 16'h0000);
    chk("mid_rst.ir", as_ir, 1'b1);
    chk("mid_rst.busy", as_busy, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (as_ov || au_ov) saw = 1'b1;
    end
    chk("mid_rst.dropped", saw, 1'b0);

    // Backpressure with MUL_LAT=2.
    @(negedge clk);
    b_or = 1'b0; b_x = 8'h80; b_y = 8'h7F; b_s = 1'b1; b_iv = 1'b1;
    @(posedge clk); #1 b_iv = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("bp.early", bo_ov, 1'b0);
    @(posedge clk);
    #1;
    chk("bp.valid", bo_ov, 1'b1);
    chk("bp.prod", bo_o, 16'hC080);
    b_x = 8'h55; b_y = 8'h55; b_s = 1'b0; b_iv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp.hold_o", bo_o, 16'hC080);
      chk("bp.hold_ov", bo_ov, 1'b1);
      chk("bp.hold_ir", bo_ir, 1'b0);
    end
    @(negedge clk);
    b_or = 1'b1; b_x = 8'h12; b_y = 8'h34; b_s = 1'b0;
    #1 chk("bp.drain_ir", bo_ir, 1'b1);
    @(posedge clk);
    #1 b_iv = 1'b0;
    chk("bp.fell", bo_ov, 1'b0);
    chk("bp.busy", bo_busy, 1'b1);
    repeat (6) @(posedge clk);
    #1 chk("bp2.early", bo_ov, 1'b0);
    @(posedge clk);
    #1;
    chk("bp2.valid", bo_ov, 1'b1);
    chk("bp2.prod", bo_o, 16'h03A8);

    // Full-width edges, MUL_LAT=3.
    op_d("w_min_sq", 512'(1) << 511, 512'(1) << 511, 1'b1, 1024'(1) << 1022);
    op_d("w_ones_sq", '1, '1, 1'b0, 1024'(0) - (1024'(1) << 513) + 1024'(1));
    op_d("w_m1_x5", '1, 512'(5), 1'b1, 1024'(0) - 1024'(5));
    op_d("w_carry", (512'(1) << 256) + 512'(3), (512'(1) << 256) - 512'(1), 1'b0,
         (1024'(1) << 512) + (1024'(1) << 257) - 1024'(3));
    op_d("w_min_x3", 512'(1) << 511, 512'(3), 1'b1, 1024'(0) - (1024'(3) << 511));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
